// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// stall-vector bit positions and the per-stage stall masks.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MDU   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int STALL_W   = 6;
  localparam int STL_PC    = 0;
  localparam int STL_IF_ID = 1;
  localparam int STL_ID_EX = 2;
  localparam int STL_EX_MEM = 3;
  localparam int STL_MEM_WB = 4;
  localparam int STL_RSVD  = 5;

  // A request from stage k freezes stage k and everything upstream of it.
  localparam logic [STALL_W-1:0] MASK_IF  = 6'b000011;
  localparam logic [STALL_W-1:0] MASK_ID  = 6'b000111;
  localparam logic [STALL_W-1:0] MASK_EX  = 6'b001111;
  localparam logic [STALL_W-1:0] MASK_MEM = 6'b011111;

endpackage

// File: rtl/pipe_stall_ctrl_mdu_cycle_counter.sv
// Down-counter timing the multi-cycle EX op: load, gated decrement, clear, zero flag.
module mdu_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec_en,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec_en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: merges stage stall requests, times the MDU busy
// window and sequences the one-cycle exception flush with PC redirect.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 6,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_mem,
  input  logic              mdu_start,
  input  logic              excp_valid,
  input  logic [ADDR_W-1:0] excp_pc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              redirect,
  output logic [ADDR_W-1:0] new_pc,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic              mdu_cancel
);

  localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cancel_q;
  logic             ex_busy;
  logic [5:0]       stall_raw;

  mdu_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (MDU_LOAD),
    .dec_en   (cnt_dec),
    .clear    (excp_valid),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      cancel_q <= 1'b0;
      new_pc   <= '0;
    end else begin
      state    <= state_nxt;
      cancel_q <= (state == ST_MDU) && excp_valid;
      if (excp_valid) begin
        new_pc <= excp_pc;
      end
    end
  end

  // Exceptions win over everything, including a same-cycle mdu_start or done.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (excp_valid) begin
          state_nxt = ST_FLUSH;
        end else if (mdu_start) begin
          state_nxt = ST_MDU;
          cnt_load  = 1'b1;
        end
      end
      ST_MDU: begin
        cnt_dec = !stallreq_mem && !cnt_zero;
        if (excp_valid) begin
          state_nxt = ST_FLUSH;
        end else if (cnt_zero) begin
          state_nxt = ST_RUN;
        end
      end
      ST_FLUSH: begin
        state_nxt = excp_valid ? ST_FLUSH : ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  assign ex_busy = (state == ST_MDU) && !cnt_zero;

  always_comb begin
    stall_raw = '0;
    if (stallreq_if)  stall_raw = stall_raw | MASK_IF;
    if (stallreq_id)  stall_raw = stall_raw | MASK_ID;
    if (ex_busy)      stall_raw = stall_raw | MASK_EX;
    if (stallreq_mem) stall_raw = stall_raw | MASK_MEM;
  end

  // While reset is held the FSM may still show its old state; mask every output.
  assign stall      = (rst || excp_valid || (state == ST_FLUSH)) ? '0 : stall_raw;
  assign mdu_busy   = ex_busy && !rst;
  assign mdu_done   = (state == ST_MDU) && cnt_zero && !excp_valid && !rst;
  assign flush      = (state == ST_FLUSH) && !rst;
  assign redirect   = (state == ST_FLUSH) && !rst;
  assign mdu_cancel = cancel_q && !rst;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scenario bench for pipe_stall_ctrl: expected done/flush events are queued when
// stimulus is driven and checked by a negedge monitor when the DUT produces them.
module tb_pipe_stall_ctrl;

  localparam int MDU_CYCLES = 32;
  localparam int CNT_W      = 6;
  localparam int ADDR_W     = 32;

  localparam logic [5:0] EXP_IF  = 6'b000011;
  localparam logic [5:0] EXP_ID  = 6'b000111;
  localparam logic [5:0] EXP_EX  = 6'b001111;
  localparam logic [5:0] EXP_MEM = 6'b011111;

  logic              clk;
  logic              rst;
  logic              stallreq_if;
  logic              stallreq_id;
  logic              stallreq_mem;
  logic              mdu_start;
  logic              excp_valid;
  logic [ADDR_W-1:0] excp_pc;
  logic [5:0]        stall;
  logic              flush;
  logic              redirect;
  logic [ADDR_W-1:0] new_pc;
  logic              mdu_busy;
  logic              mdu_done;
  logic              mdu_cancel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int               at;
    logic [ADDR_W-1:0] pc;
    logic             cancel;
  } flush_ev_t;

  int        done_q[$];
  flush_ev_t flush_q[$];

  pipe_stall_ctrl #(
    .MDU_CYCLES(MDU_CYCLES),
    .CNT_W     (CNT_W),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_mem (stallreq_mem),
    .mdu_start    (mdu_start),
    .excp_valid   (excp_valid),
    .excp_pc      (excp_pc),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .new_pc       (new_pc),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done),
    .mdu_cancel   (mdu_cancel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard monitor: every done or flush/cancel pulse must match the queue head.
  always @(negedge clk) begin
    if (mdu_done === 1'b1) begin
      total++;
      if (done_q.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: mdu_done=1 at cycle %0d, none expected", cyc);
      end else begin
        int e;
        e = done_q.pop_front();
        if (cyc !== e) begin
          bad++;
          $display("FAIL done_cycle: got cycle %0d, want %0d", cyc, e);
        end
      end
    end
    if (flush === 1'b1 || mdu_cancel === 1'b1) begin
      total++;
      if (flush_q.size() == 0) begin
        bad++;
        $display("FAIL flush_unexpected: flush=%b cancel=%b at cycle %0d", flush, mdu_cancel, cyc);
      end else begin
        flush_ev_t f;
        f = flush_q.pop_front();
        if (cyc !== f.at || flush !== 1'b1 || redirect !== 1'b1 ||
            new_pc !== f.pc || mdu_cancel !== f.cancel) begin
          bad++;
          $display("FAIL flush_event: cyc=%0d flush=%b redir=%b pc=%h cancel=%b, want cyc=%0d 1 1 pc=%h cancel=%b",
                   cyc, flush, redirect, new_pc, mdu_cancel, f.at, f.pc, f.cancel);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stallreq_id = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (stall !== 6'b0 || flush !== 1'b0 || redirect !== 1'b0 || mdu_busy !== 1'b0 ||
        new_pc !== '0 || mdu_done !== 1'b0 || mdu_cancel !== 1'b0) begin
      bad++;
      $display("FAIL reset_held: stall=%b flush=%b redir=%b busy=%b pc=%h done=%b cancel=%b, want all 0",
               stall, flush, redirect, mdu_busy, new_pc, mdu_done, mdu_cancel);
    end
    step();
    rst = 1'b0;
    stallreq_id = 1'b0;
    @(negedge clk);
    total++;
    if (stall !== 6'b0 || flush !== 1'b0 || mdu_busy !== 1'b0 || new_pc !== '0) begin
      bad++;
      $display("FAIL reset_release: stall=%b flush=%b busy=%b pc=%h, want 0", stall, flush, mdu_busy, new_pc);
    end
  endtask

  task automatic test_stall_merge();
    for (int i = 0; i < 8; i++) begin
      logic [5:0] exp;
      step();
      stallreq_if  = i[0];
      stallreq_id  = i[1];
      stallreq_mem = i[2];
      exp = i[2] ? EXP_MEM : i[1] ? EXP_ID : i[0] ? EXP_IF : 6'b0;
      @(negedge clk);
      total++;
      if (stall !== exp) begin
        bad++;
        $display("FAIL stall_merge[%0d]: stall=%b want %b", i, stall, exp);
      end
    end
    step();
    stallreq_if = 1'b0;
    stallreq_id = 1'b0;
    stallreq_mem = 1'b0;
  endtask

  // Runs one op; mem stall held for cycles [ms_lo, ms_hi) relative to start.
  task automatic run_mdu(input string name, input int ms_lo, input int ms_hi);
    int s;
    int slip;
    slip = ms_hi - ms_lo;
    step();
    s = cyc;
    mdu_start = 1'b1;
    done_q.push_back(s + MDU_CYCLES + slip);
    step();
    for (int k = 1; k < MDU_CYCLES + slip; k++) begin
      logic [5:0] exp;
      mdu_start    = (k == 15);
      stallreq_mem = (k >= ms_lo) && (k < ms_hi);
      exp = stallreq_mem ? EXP_MEM : EXP_EX;
      @(negedge clk);
      total++;
      if (stall !== exp || mdu_busy !== 1'b1) begin
        bad++;
        $display("FAIL %s_busy k=%0d: stall=%b busy=%b, want %b 1", name, k, stall, mdu_busy, exp);
      end
      step();
    end
    mdu_start = 1'b0;
    stallreq_mem = 1'b0;
    @(negedge clk);
    total++;
    if (stall !== 6'b0 || mdu_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_end: stall=%b busy=%b, want 0 0", name, stall, mdu_busy);
    end
    repeat (6) step();
    total++;
    if (done_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_done_missing: %0d done pulses outstanding", name, done_q.size());
    end
  endtask

  task automatic test_mdu_run();
    run_mdu("mdu_run", 0, 0);
  endtask

  task automatic test_mem_stall();
    run_mdu("mem_stall", 5, 8);
  endtask

  task automatic test_excp_cancel();
    int s;
    flush_ev_t f;
    step();
    s = cyc;
    mdu_start = 1'b1;
    step();
    mdu_start = 1'b0;
    repeat (9) step();
    excp_valid = 1'b1;
    excp_pc = 32'hBFC00380;
    stallreq_id = 1'b1;
    mdu_start = 1'b1;
    f.at = s + 11; f.pc = 32'hBFC00380; f.cancel = 1'b1;
    flush_q.push_back(f);
    @(negedge clk);
    total++;
    if (stall !== 6'b0) begin
      bad++;
      $display("FAIL excp_override: stall=%b want 000000", stall);
    end
    step();
    excp_valid = 1'b0;
    stallreq_id = 1'b0;
    mdu_start = 1'b0;
    @(negedge clk);
    total++;
    if (stall !== 6'b0 || mdu_busy !== 1'b0) begin
      bad++;
      $display("FAIL excp_flush_cycle: stall=%b busy=%b want 0 0", stall, mdu_busy);
    end
    step();
    @(negedge clk);
    total++;
    if (flush !== 1'b0 || mdu_busy !== 1'b0 || new_pc !== 32'hBFC00380 || stall !== 6'b0) begin
      bad++;
      $display("FAIL excp_after: flush=%b busy=%b pc=%h stall=%b, want 0 0 bfc00380 0",
               flush, mdu_busy, new_pc, stall);
    end
    repeat (MDU_CYCLES + 4) step();
    total++;
    if (flush_q.size() !== 0) begin
      bad++;
      $display("FAIL excp_flush_missing: %0d flush events outstanding", flush_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int t;
    flush_ev_t f;
    step();
    t = cyc;
    excp_valid = 1'b1;
    excp_pc = 32'h80000180;
    f.at = t + 1; f.pc = 32'h80000180; f.cancel = 1'b0;
    flush_q.push_back(f);
    step();
    excp_pc = 32'h80000200;
    f.at = t + 2; f.pc = 32'h80000200; f.cancel = 1'b0;
    flush_q.push_back(f);
    step();
    excp_valid = 1'b0;
    excp_pc = 32'h12345678;
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (flush !== 1'b0 || new_pc !== 32'h80000200) begin
        bad++;
        $display("FAIL b2b_hold[%0d]: flush=%b pc=%h, want 0 80000200", k, flush, new_pc);
      end
      step();
    end
    total++;
    if (flush_q.size() !== 0) begin
      bad++;
      $display("FAIL b2b_missing: %0d flush events outstanding", flush_q.size());
    end
  endtask

  task automatic test_reset_mid();
    step();
    mdu_start = 1'b1;
    step();
    mdu_start = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mdu_busy !== 1'b0 || stall !== 6'b0 || mdu_done !== 1'b0 || mdu_cancel !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_mdu: busy=%b stall=%b done=%b cancel=%b, want 0", mdu_busy, stall, mdu_done, mdu_cancel);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mdu_busy !== 1'b0 || stall !== 6'b0) begin
      bad++;
      $display("FAIL rst_mid_mdu_after: busy=%b stall=%b, want 0 0", mdu_busy, stall);
    end
    repeat (MDU_CYCLES + 4) step();
    excp_valid = 1'b1;
    excp_pc = 32'hCAFEF00D;
    step();
    excp_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (flush !== 1'b0 || redirect !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_flush: flush=%b redir=%b, want 0 0", flush, redirect);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (flush !== 1'b0 || new_pc !== '0) begin
      bad++;
      $display("FAIL rst_mid_flush_after: flush=%b pc=%h, want 0 0", flush, new_pc);
    end
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1;
    stallreq_if = 1'b0;
    stallreq_id = 1'b0;
    stallreq_mem = 1'b0;
    mdu_start = 1'b0;
    excp_valid = 1'b0;
    excp_pc = '0;
    test_reset();
    test_stall_merge();
    test_mdu_run();
    test_mem_stall();
    test_excp_cancel();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (done_q.size() !== 0 || flush_q.size() !== 0) begin
      bad++;
      $display("FAIL final_queues: done=%0d flush=%0d outstanding", done_q.size(), flush_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
